// File: rtl/gcd_pkg.sv
// Shared types and constants for the GCD core and its host sequencer.
package gcd_pkg;

  localparam int GCD_WIDTH = 16;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CORE_RST,
    S_WAIT,
    S_RESP
  } gcd_host_state_e;

endpackage

// File: rtl/gcd_cycle_counter.sv
// Clearable up-counter that flags when it has reached a run-time terminal value.
module gcd_cycle_counter #(
  parameter int CNT_W = 4
) (
  input  logic             clk_i,
  input  logic             nreset_i,
  input  logic             clear_i,
  input  logic             enable_i,
  input  logic [CNT_W-1:0] terminal_i,
  output logic             done_o
);

  logic [CNT_W-1:0] count_q;

  assign done_o = enable_i && (count_q == terminal_i);

  // Holds at the terminal value, so it can never wrap.
  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      count_q <= '0;
    end else if (clear_i) begin
      count_q <= '0;
    end else if (enable_i && !done_o) begin
      count_q <= count_q + 1'b1;
    end
  end

endmodule

// File: rtl/gcd_host_seq.sv
// Host-side sequencer for the GCD core: resets, loads and runs the core once per request,
// then returns its result (or a timeout) on a valid/ready response port.
module gcd_host_seq
  import gcd_pkg::*;
#(
  parameter int WIDTH          = GCD_WIDTH,
  parameter int RST_CYCLES     = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic             clk_i,
  input  logic             nreset_i,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [WIDTH-1:0] req_a_i,
  input  logic [WIDTH-1:0] req_b_i,
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic [WIDTH-1:0] rsp_gcd_o,
  output logic             rsp_timeout_o,
  output logic             busy_o,
  output logic             core_nreset_o,
  output logic             core_enable_o,
  output logic [WIDTH-1:0] core_a_o,
  output logic [WIDTH-1:0] core_b_o,
  input  logic             core_flag_finish_i,
  input  logic [WIDTH-1:0] core_result_i
);

  localparam int CNT_MAX = (TIMEOUT_CYCLES > RST_CYCLES) ? TIMEOUT_CYCLES : RST_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] RST_TERM = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_TERM  = CNT_W'(TIMEOUT_CYCLES - 1);

  gcd_host_state_e  state_q, state_d;
  logic             cnt_clear, cnt_enable, cnt_done;
  logic [CNT_W-1:0] cnt_term;
  logic             core_live_q;
  logic             operand_zero;

  assign operand_zero = (req_a_i == '0) || (req_b_i == '0);

  assign cnt_clear  = (state_d != state_q);
  assign cnt_enable = (state_q == S_CORE_RST) || (state_q == S_WAIT);
  assign cnt_term   = (state_q == S_CORE_RST) ? RST_TERM : TO_TERM;

  gcd_cycle_counter #(
    .CNT_W(CNT_W)
  ) u_counter (
    .clk_i     (clk_i),
    .nreset_i  (nreset_i),
    .clear_i   (cnt_clear),
    .enable_i  (cnt_enable),
    .terminal_i(cnt_term),
    .done_o    (cnt_done)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:     if (req_valid_i) state_d = operand_zero ? S_RESP : S_CORE_RST;
      S_CORE_RST: if (cnt_done) state_d = S_WAIT;
      S_WAIT:     if (core_flag_finish_i || cnt_done) state_d = S_RESP;
      S_RESP:     if (rsp_ready_i) state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      state_q     <= S_IDLE;
      core_live_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      core_live_q <= (state_d == S_WAIT);
    end
  end

  // Finish outranks timeout when both land on the same cycle.
  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      core_a_o      <= '0;
      core_b_o      <= '0;
      rsp_gcd_o     <= '0;
      rsp_timeout_o <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_valid_i) begin
            core_a_o <= req_a_i;
            core_b_o <= req_b_i;
            if (operand_zero) begin
              rsp_gcd_o     <= req_a_i | req_b_i;
              rsp_timeout_o <= 1'b0;
            end
          end
        end
        S_WAIT: begin
          if (core_flag_finish_i) begin
            rsp_gcd_o     <= core_result_i;
            rsp_timeout_o <= 1'b0;
          end else if (cnt_done) begin
            rsp_gcd_o     <= '0;
            rsp_timeout_o <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign req_ready_o   = (state_q == S_IDLE);
  assign busy_o        = (state_q != S_IDLE);
  assign rsp_valid_o   = (state_q == S_RESP);
  assign core_nreset_o = core_live_q;
  assign core_enable_o = core_live_q;

endmodule
